// File: rtl/pru_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pru_cmd_scheduler
// Brief   : Round-robin arbitration of two draw-command requesters into a
//           shared FIFO, issuing one command at a time to the PRU rasteriser
//           with a single-cycle start pulse and operands held until the next
//           issue.
// Options : PRU_TIMEOUT_EN - adds a 16-bit done watchdog and a sticky
//           timeout_err flag; without it WAIT_DONE waits indefinitely.
// Revision: 1.0 - initial release
// ============================================================================
module pru_cmd_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid,
  input  logic [74:0]                   req0_cmd,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [74:0]                   req1_cmd,
  output logic                          req1_ready,
  output logic [1:0]                    color,
  output logic [9:0]                    row,
  output logic [8:0]                    col,
  output logic [9:0]                    width,
  output logic [8:0]                    height_radius,
  output logic [31:0]                   bitmap_addr,
  output logic [1:0]                    shape_select,
  output logic                          subtract,
  output logic                          start,
  input  logic                          busy,
  input  logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          issue;
  logic          timeout_hit;

  logic [74:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          rr_pref1;
  logic          grant0;
  logic          grant1;
  logic          push0;
  logic          push1;
  logic          push;
  logic [74:0]   push_cmd;
  logic [74:0]   head;

  // busy is status only; sequencing relies solely on done
  logic unused_busy;
  assign unused_busy = busy;

  // full is taken from the registered count, so a same-cycle pop never frees a slot
  assign full       = (count == DEPTH_C);
  assign fifo_count = count;
  assign idle       = (state == ST_IDLE) && (count == '0);

  // Grant: a lone requester wins; with both valid the one not granted last wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && (!req1_valid || !rr_pref1)) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0 & ~full;
  assign req1_ready = grant1 & ~full;
  assign push0      = req0_valid & req0_ready;
  assign push1      = req1_valid & req1_ready;
  assign push       = push0 | push1;
  assign push_cmd   = push1 ? req1_cmd : req0_cmd;
  assign head       = mem[rd_ptr];

  // Round-robin pointer moves only when a transfer actually happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pref1 <= 1'b0;
    end else if (push0) begin
      rr_pref1 <= 1'b1;
    end else if (push1) begin
      rr_pref1 <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark them empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  // FIFO pointers and occupancy; push+pop together leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, issue})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; done during LAUNCH is deliberately ignored
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (issue) next_state = ST_LAUNCH;
      ST_LAUNCH: next_state = ST_WAIT;
      ST_WAIT:   if (done || timeout_hit) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: pop the head whenever idle with work queued
  always_comb begin
    issue = 1'b0;
    if ((state == ST_IDLE) && (count != '0)) begin
      issue = 1'b1;
    end
  end

  // PRU operand and start registers; operands hold until the next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start         <= 1'b0;
      bitmap_addr   <= '0;
      subtract      <= 1'b0;
      shape_select  <= '0;
      color         <= '0;
      row           <= '0;
      col           <= '0;
      width         <= '0;
      height_radius <= '0;
    end else begin
      start <= issue;
      if (issue) begin
        bitmap_addr   <= head[74:43];
        subtract      <= head[42];
        shape_select  <= head[41:40];
        color         <= head[39:38];
        row           <= head[37:28];
        col           <= head[27:19];
        width         <= head[18:9];
        height_radius <= head[8:0];
      end
    end
  end

`ifdef PRU_TIMEOUT_EN
  // Watchdog fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_DONE
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  logic        timeout_q;

  assign timeout_hit = (state == ST_WAIT) && !done && (wd_cnt == WD_LIMIT);
  assign timeout_err = timeout_q;

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_LAUNCH) begin
        wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire
